// File: rtl/sync_fifo_fwft.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo_fwft
//  Description : Parametrised single-clock FIFO with an optional
//                first-word-fall-through read mode. It also provides an
//                occupancy count, almost-full and almost-empty thresholds,
//                and sticky overflow/underflow error flags with a clear.
//  Revision    : 1.0  initial release
// ============================================================================
module sync_fifo_fwft #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 4,
    parameter int FWFT     = 0,
    parameter int AF_LEVEL = 12,
    parameter int AE_LEVEL = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wrt,
    input  logic              rd,
    input  logic [DATA_W-1:0] din,
    input  logic              clr_err,
    output logic [DATA_W-1:0] dout,
    output logic              empty,
    output logic              full,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow
);

    localparam int              c_DEPTH     = 1 << ADDR_W;
    localparam logic [ADDR_W:0] c_DEPTH_CNT = (ADDR_W + 1)'(c_DEPTH);
    localparam logic [ADDR_W:0] c_AF_LVL    = (ADDR_W + 1)'(AF_LEVEL);
    localparam logic [ADDR_W:0] c_AE_LVL    = (ADDR_W + 1)'(AE_LEVEL);
    localparam logic [ADDR_W:0] c_CNT_ONE   = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] c_PTR_ONE = ADDR_W'(1);

    // Storage array. It has no reset because its contents do not matter
    // until they are written.
    logic [DATA_W-1:0] r_mem [c_DEPTH];

    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic              r_overflow;
    logic              r_underflow;

    logic              w_empty;
    logic              w_full;
    logic              w_rd_ok;
    logic              w_wr_ok;
    logic              w_ovf_set;
    logic              w_udf_set;

    // Full and empty come from the occupancy count, not from a pointer
    // comparison. This lets the pointers wrap freely, and equal pointers
    // are never ambiguous.
    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == c_DEPTH_CNT);

    // A read is accepted only when data is present. When the FIFO is full,
    // a write is still accepted if a read frees a slot on the same edge.
    assign w_rd_ok = rd & ~w_empty;
    assign w_wr_ok = wrt & (~w_full | w_rd_ok);

    // Error set conditions. These are the rejected requests.
    assign w_ovf_set = wrt & w_full & ~w_rd_ok;
    assign w_udf_set = rd & w_empty;

    // Store accepted write data at the write pointer.
    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // The write pointer advances on each accepted write and wraps modulo the depth.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
        end else if (w_wr_ok) begin
            r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
        end
    end

    // The read pointer advances on each accepted read and wraps modulo the depth.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_ptr <= '0;
        end else if (w_rd_ok) begin
            r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
        end
    end

    // Occupancy tracks the net effect of the accepted operations. A
    // simultaneous write and read leaves the count unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else begin
            case ({w_wr_ok, w_rd_ok})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky error flags. A new set event takes priority over a clear
    // arriving on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_overflow  <= w_ovf_set | (r_overflow  & ~clr_err);
            r_underflow <= w_udf_set | (r_underflow & ~clr_err);
        end
    end

    // Read data path. It is selected at elaboration from the read mode.
    if (FWFT != 0) begin : g_fwft
        // The head word is visible combinationally whenever data is held.
        // The output is zero while the FIFO is empty, which also gives the
        // required zero output during reset.
        assign dout = w_empty ? '0 : r_mem[r_rd_ptr];
    end else begin : g_std
        logic [DATA_W-1:0] r_dout;

        // Registered read. The register loads only on an accepted read and
        // otherwise holds its value.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_dout <= '0;
            end else if (w_rd_ok) begin
                r_dout <= r_mem[r_rd_ptr];
            end
        end

        assign dout = r_dout;
    end

    assign empty        = w_empty;
    assign full         = w_full;
    assign almost_full  = (r_count >= c_AF_LVL);
    assign almost_empty = (r_count <= c_AE_LVL);
    assign count        = r_count;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_fwft.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sync_fifo_fwft
//  Description : Directed self-checking bench for sync_fifo_fwft. One
//                instance uses the standard read mode and one uses the
//                fall-through read mode.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_sync_fifo_fwft;

    logic       clk;
    logic       rst;

    // Standard-mode instance signals
    logic       wrt, rd, clr_err;
    logic [7:0] din, dout;
    logic       empty, full, almost_full, almost_empty, overflow, underflow;
    logic [4:0] count;

    // Fall-through instance signals
    logic       f_wrt, f_rd, f_clr_err;
    logic [7:0] f_din, f_dout;
    logic       f_empty, f_full, f_almost_full, f_almost_empty, f_overflow, f_underflow;
    logic [4:0] f_count;

    int errors = 0;
    int checks = 0;

    sync_fifo_fwft #(.DATA_W(8), .ADDR_W(4), .FWFT(0), .AF_LEVEL(12), .AE_LEVEL(2)) u_std (
        .clk(clk), .rst(rst), .wrt(wrt), .rd(rd), .din(din), .clr_err(clr_err),
        .dout(dout), .empty(empty), .full(full), .almost_full(almost_full),
        .almost_empty(almost_empty), .count(count), .overflow(overflow), .underflow(underflow)
    );

    sync_fifo_fwft #(.DATA_W(8), .ADDR_W(4), .FWFT(1), .AF_LEVEL(12), .AE_LEVEL(2)) u_fwft (
        .clk(clk), .rst(rst), .wrt(f_wrt), .rd(f_rd), .din(f_din), .clr_err(f_clr_err),
        .dout(f_dout), .empty(f_empty), .full(f_full), .almost_full(f_almost_full),
        .almost_empty(f_almost_empty), .count(f_count), .overflow(f_overflow), .underflow(f_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock. Outputs are then sampled 1 ns after the rising edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        checks++;
        if ({count, empty, full, almost_full, almost_empty} !== {5'd0, 1'b1, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_flags: got cnt=%0d e=%b f=%b af=%b ae=%b, want 0 1 0 0 1",
                     count, empty, full, almost_full, almost_empty);
        end
        checks++;
        if ({dout, overflow, underflow} !== {8'h00, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_data_err: got dout=%h ov=%b un=%b, want 00 0 0", dout, overflow, underflow);
        end
        // Build up a count of 5 with a non-zero dout, then reset mid-cycle.
        wrt = 1'b1;
        for (int i = 0; i < 6; i++) begin
            din = 8'(8'h11 + i);
            tick();
        end
        wrt = 1'b0;
        rd  = 1'b1;
        tick();
        rd  = 1'b0;
        checks++;
        if ({count, dout} !== {5'd5, 8'h11}) begin
            errors++;
            $display("FAIL prereset_state: got cnt=%0d dout=%h, want 5 11", count, dout);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({count, empty, almost_empty, full, dout} !== {5'd0, 1'b1, 1'b1, 1'b0, 8'h00}) begin
            errors++;
            $display("FAIL async_reset: got cnt=%0d e=%b ae=%b f=%b dout=%h, want 0 1 1 0 00",
                     count, empty, almost_empty, full, dout);
        end
        rst = 1'b0;
        // After reset is released the FIFO must behave as a fresh one.
        wrt = 1'b1;
        din = 8'h77;
        tick();
        wrt = 1'b0;
        rd  = 1'b1;
        tick();
        rd  = 1'b0;
        checks++;
        if ({count, dout} !== {5'd0, 8'h77}) begin
            errors++;
            $display("FAIL post_reset_fresh: got cnt=%0d dout=%h, want 0 77", count, dout);
        end
    endtask

    task automatic test_fill_drain;
        wrt = 1'b1;
        for (int i = 0; i < 16; i++) begin
            din = 8'(i);
            tick();
            checks++;
            if ({count, full, almost_full, empty, almost_empty} !==
                {5'(i + 1), (i == 15), (i >= 11), 1'b0, (i + 1 <= 2)}) begin
                errors++;
                $display("FAIL fill_%0d: got cnt=%0d f=%b af=%b e=%b ae=%b", i, count, full,
                         almost_full, empty, almost_empty);
            end
        end
        din = 8'hEE;
        tick();
        wrt = 1'b0;
        checks++;
        if ({overflow, count, full} !== {1'b1, 5'd16, 1'b1}) begin
            errors++;
            $display("FAIL overflow_17th: got ov=%b cnt=%0d f=%b, want 1 16 1", overflow, count, full);
        end
        rd = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            checks++;
            if ({dout, count, empty, almost_empty, full} !==
                {8'(i), 5'(15 - i), (i == 15), (15 - i <= 2), 1'b0}) begin
                errors++;
                $display("FAIL drain_%0d: got dout=%h cnt=%0d e=%b ae=%b f=%b, want dout=%h",
                         i, dout, count, empty, almost_empty, full, 8'(i));
            end
        end
        tick();
        rd = 1'b0;
        checks++;
        if ({underflow, count, dout} !== {1'b1, 5'd0, 8'h0F}) begin
            errors++;
            $display("FAIL underflow_extra_rd: got un=%b cnt=%0d dout=%h, want 1 0 0f", underflow, count, dout);
        end
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        checks++;
        if ({overflow, underflow} !== 2'b00) begin
            errors++;
            $display("FAIL clr_err_both: got ov=%b un=%b, want 0 0", overflow, underflow);
        end
    endtask

    task automatic test_simul_full;
        wrt = 1'b1;
        for (int i = 0; i < 16; i++) begin
            din = 8'(i);
            tick();
        end
        din = 8'hAA;
        rd  = 1'b1;
        tick();
        wrt = 1'b0;
        checks++;
        if ({count, overflow, dout} !== {5'd16, 1'b0, 8'h00}) begin
            errors++;
            $display("FAIL simul_full: got cnt=%0d ov=%b dout=%h, want 16 0 00", count, overflow, dout);
        end
        for (int i = 0; i < 16; i++) begin
            tick();
            checks++;
            if (dout !== ((i < 15) ? 8'(i + 1) : 8'hAA)) begin
                errors++;
                $display("FAIL simul_full_drain_%0d: got dout=%h want %h", i, dout,
                         ((i < 15) ? 8'(i + 1) : 8'hAA));
            end
        end
        rd = 1'b0;
        checks++;
        if (count !== 5'd0) begin
            errors++;
            $display("FAIL simul_full_end_count: got %0d want 0", count);
        end
    endtask

    task automatic test_simul_empty;
        wrt = 1'b1;
        rd  = 1'b1;
        din = 8'h55;
        tick();
        wrt = 1'b0;
        rd  = 1'b0;
        checks++;
        if ({underflow, count, empty, dout} !== {1'b1, 5'd1, 1'b0, 8'hAA}) begin
            errors++;
            $display("FAIL simul_empty: got un=%b cnt=%0d e=%b dout=%h, want 1 1 0 aa",
                     underflow, count, empty, dout);
        end
        rd = 1'b1;
        tick();
        rd = 1'b0;
        checks++;
        if ({dout, count} !== {8'h55, 5'd0}) begin
            errors++;
            $display("FAIL simul_empty_read: got dout=%h cnt=%0d, want 55 0", dout, count);
        end
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
    endtask

    task automatic test_wrap;
        wrt = 1'b1;
        din = 8'h80;
        tick();
        rd = 1'b1;
        for (int i = 0; i < 40; i++) begin
            din = 8'(129 + i);
            tick();
            checks++;
            if ({dout, count} !== {8'(128 + i), 5'd1}) begin
                errors++;
                $display("FAIL wrap_%0d: got dout=%h cnt=%0d, want %h 1", i, dout, count, 8'(128 + i));
            end
        end
        wrt = 1'b0;
        tick();
        rd = 1'b0;
        checks++;
        if ({dout, count} !== {8'hA8, 5'd0}) begin
            errors++;
            $display("FAIL wrap_last: got dout=%h cnt=%0d, want a8 0", dout, count);
        end
    endtask

    task automatic test_clr_err;
        rd = 1'b1;
        tick();
        rd  = 1'b0;
        wrt = 1'b1;
        for (int i = 0; i < 17; i++) begin
            din = 8'(i);
            tick();
        end
        wrt = 1'b0;
        checks++;
        if ({overflow, underflow} !== 2'b11) begin
            errors++;
            $display("FAIL errs_set: got ov=%b un=%b, want 1 1", overflow, underflow);
        end
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        checks++;
        if ({overflow, underflow, count} !== {2'b00, 5'd16}) begin
            errors++;
            $display("FAIL clr_pulse: got ov=%b un=%b cnt=%0d, want 0 0 16", overflow, underflow, count);
        end
        rd = 1'b1;
        repeat (16) tick();
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        rd      = 1'b0;
        checks++;
        if ({underflow, overflow} !== 2'b10) begin
            errors++;
            $display("FAIL clr_vs_set: got un=%b ov=%b, want 1 0", underflow, overflow);
        end
    endtask

    task automatic test_fwft;
        checks++;
        if ({f_empty, f_count} !== {1'b1, 5'd0}) begin
            errors++;
            $display("FAIL fwft_start: got e=%b cnt=%0d, want 1 0", f_empty, f_count);
        end
        f_wrt = 1'b1;
        f_din = 8'h3C;
        tick();
        f_wrt = 1'b0;
        checks++;
        if ({f_empty, f_dout} !== {1'b0, 8'h3C}) begin
            errors++;
            $display("FAIL fwft_fall_through: got e=%b dout=%h, want 0 3c", f_empty, f_dout);
        end
        f_wrt = 1'b1;
        f_din = 8'h3D;
        tick();
        f_wrt = 1'b0;
        checks++;
        if ({f_dout, f_count} !== {8'h3C, 5'd2}) begin
            errors++;
            $display("FAIL fwft_hold_head: got dout=%h cnt=%0d, want 3c 2", f_dout, f_count);
        end
        f_rd = 1'b1;
        tick();
        f_rd = 1'b0;
        checks++;
        if ({f_dout, f_count} !== {8'h3D, 5'd1}) begin
            errors++;
            $display("FAIL fwft_pop: got dout=%h cnt=%0d, want 3d 1", f_dout, f_count);
        end
        f_rd = 1'b1;
        tick();
        f_rd = 1'b0;
        checks++;
        if ({f_empty, f_count, f_underflow} !== {1'b1, 5'd0, 1'b0}) begin
            errors++;
            $display("FAIL fwft_empty_again: got e=%b cnt=%0d un=%b, want 1 0 0", f_empty, f_count, f_underflow);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        {wrt, rd, clr_err, f_wrt, f_rd, f_clr_err} = '0;
        din   = 8'h00;
        f_din = 8'h00;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        test_reset();
        test_fill_drain();
        test_simul_full();
        test_simul_empty();
        test_wrap();
        test_clr_err();
        test_fwft();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
